prescaled_down_timer: RTL and testbench
=======================================

Name: prescaled_down_timer

Overview:
- Loadable, prescaled binary down-counter: the counting-down counterpart of the free-running up-counter used for visible display sequencing.
- Counts a loaded value down to zero at one step per PRESC clocks.
- Emits a one-cycle zero_tick on reaching zero, then stops or auto-reloads.
- Sits between user controls (buttons/switches) and the display/LED logic as a countdown timer.

Parameters:
N, 8, width of count value q and load_val
PRESC, 7400000, clocks per count step (>=2)
PW, 23, prescaler counter width; must satisfy 2**PW > PRESC-1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
load  input  1  sync; capture load_val into q and reload register
load_val  input  N  value captured on load
start  input  1  sync; begin/resume/restart counting
pause  input  1  sync; freeze counting while running
auto_reload  input  1  level; 1 = reload instead of stopping at zero
q  output  N  current count (registered)
zero_tick  output  1  one-cycle pulse, registered, on each arrival at zero
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (async, any time, mid-count included):
  - q=0, reload_reg=0, presc=0, state=IDLE, zero_tick=0, busy=0, done=0.
- States: IDLE, RUN, PAUSED, DONE. busy = (state==RUN); done = (state==DONE).
- Control priority each cycle: reset > load > pause > start.
- load (any state): q<=load_val, reload_reg<=load_val, presc<=0, state<=IDLE. Overrides a step in the same cycle.
- IDLE:
  - start with q!=0 -> RUN, presc<=0.
  - start with q==0 -> ignored, stay IDLE.
- RUN:
  - presc increments each cycle.
  - When presc==PRESC-1: presc<=0 and one step occurs.
  - Step with q>1: q<=q-1.
  - Step with q==1 and auto_reload=1 and reload_reg!=0: q<=reload_reg, zero_tick<=1, stay RUN. q never shows 0 in this mode.
  - Step with q==1 otherwise: q<=0, zero_tick<=1, state<=DONE.
  - pause (no load): state<=PAUSED; presc and q hold. A step coinciding with pause is suppressed.
  - pause and start both high: pause wins.
- PAUSED:
  - q and presc hold.
  - start with pause low -> RUN, resuming from held presc (no restart of the partial period).
  - start with pause high -> stay PAUSED.
- DONE:
  - q=0 holds.
  - start -> q<=reload_reg, presc<=0, RUN; ignored if reload_reg==0 (stay DONE).
- zero_tick timing:
  - High exactly one cycle: the first cycle q shows 0 (stop mode) or the reloaded value (reload mode).
  - Low in all other cycles.
- Arithmetic:
  - q never underflows; the decrement only occurs for q>=2.
  - presc compare is an exact equality on PW bits.
- auto_reload is sampled only at the step where q==1. Changing it mid-count has no other effect.
- Latency:
  - From RUN entry to first decrement: exactly PRESC clocks.
  - Between steps: PRESC clocks while uninterrupted.

Test Plan:
- N=8, PRESC=4. Reset high mid-run -> q=0, busy=0, done=0, zero_tick=0 immediately (async), state IDLE after release.
- load_val=3, load, start -> q: 3 for 4 clks, 2 for 4, 1 for 4, then 0. zero_tick high exactly 1 clk when q becomes 0. done=1, busy=0 thereafter.
- load_val=2, auto_reload=1, start, run 20 clks -> q sequence 2,1,2,1,2. zero_tick pulses every 8 clks coincident with q returning to 2. done stays 0.
- load_val=5, start, pause after 2 clks of the first period, hold 10 clks, then start -> q=5 throughout pause. First decrement 2 clks after resume.
- load asserted in the same cycle as a pending step (presc==3, q=4), load_val=9 -> q=9, IDLE, no decrement, no zero_tick. start with q=0 in IDLE -> stays IDLE, busy=0.
- In DONE after count from 3, start -> q=3, RUN, next decrement after 4 clks. pause+start together while in RUN -> PAUSED.

Source files
------------

// File: rtl/prescaled_down_timer.sv
// Loadable, prescaled binary down-counter for countdown displays: one step every
// PRESC clocks, a one-cycle zero_tick on arrival at zero, then stop or auto-reload.
module prescaled_down_timer #(
    parameter int N     = 8,
    parameter int PRESC = 7400000,
    parameter int PW    = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [N-1:0] q,
    output logic         zero_tick,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [N-1:0]  ONE        = N'(1);

    state_t        state, state_d;
    logic [N-1:0]  q_d;
    logic [N-1:0]  reload_reg, reload_d;
    logic [PW-1:0] presc, presc_d;
    logic          tick_d;

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        q_d      = q;
        reload_d = reload_reg;
        presc_d  = presc;
        tick_d   = 1'b0;

        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            presc_d  = '0;
            state_d  = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && q != '0) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    // A step landing in the same cycle as pause is dropped; presc stays put.
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (presc == PRESC_LAST) begin
                        presc_d = '0;
                        if (q > ONE) begin
                            q_d = q - ONE;
                        end else if (auto_reload && reload_reg != '0) begin
                            q_d    = reload_reg;
                            tick_d = 1'b1;
                        end else begin
                            q_d     = '0;
                            tick_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        presc_d = presc + PW'(1);
                    end
                end
                S_PAUSED: begin
                    if (start && !pause) state_d = S_RUN;
                end
                S_DONE: begin
                    if (start && reload_reg != '0) begin
                        q_d     = reload_reg;
                        presc_d = '0;
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            q          <= '0;
            reload_reg <= '0;
            presc      <= '0;
            zero_tick  <= 1'b0;
        end else begin
            state      <= state_d;
            q          <= q_d;
            reload_reg <= reload_d;
            presc      <= presc_d;
            zero_tick  <= tick_d;
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_prescaled_down_timer.sv
// Self-checking bench for prescaled_down_timer (N=8, PRESC=4): a cycle-level reference
// model checked every negedge, plus hand-computed literal checks at key points.
module tb_prescaled_down_timer;

    localparam int N     = 8;
    localparam int PRESC = 4;
    localparam int PW    = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [N-1:0] load_val;
    logic         start;
    logic         pause;
    logic         auto_reload;
    logic [N-1:0] q;
    logic         zero_tick;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    prescaled_down_timer #(.N(N), .PRESC(PRESC), .PW(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .q           (q),
        .zero_tick   (zero_tick),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: m_left counts clocks remaining until the next step.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_t;
    mstate_t m_st;
    int      m_q, m_reload, m_left;
    bit      m_tick;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = M_IDLE; m_q = 0; m_reload = 0; m_left = PRESC; m_tick = 0;
        end else begin
            m_tick = 0;
            if (load) begin
                m_q = int'(load_val); m_reload = int'(load_val); m_left = PRESC; m_st = M_IDLE;
            end else begin
                case (m_st)
                    M_IDLE: if (start && m_q != 0) begin m_st = M_RUN; m_left = PRESC; end
                    M_RUN: begin
                        if (pause) m_st = M_PAUSED;
                        else begin
                            m_left = m_left - 1;
                            if (m_left == 0) begin
                                m_left = PRESC;
                                if (m_q >= 2) m_q = m_q - 1;
                                else if (auto_reload && m_reload != 0) begin m_q = m_reload; m_tick = 1; end
                                else begin m_q = 0; m_tick = 1; m_st = M_DONE; end
                            end
                        end
                    end
                    M_PAUSED: if (start && !pause) m_st = M_RUN;
                    M_DONE: if (start && m_reload != 0) begin m_q = m_reload; m_left = PRESC; m_st = M_RUN; end
                    default: m_st = M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model_q", q, m_q);
            check("model_zero_tick", zero_tick, m_tick);
            check("model_busy", busy, m_st == M_RUN);
            check("model_done", done, m_st == M_DONE);
        end
    end

    initial begin
        reset = 1'b1; load = 0; load_val = '0; start = 0; pause = 0; auto_reload = 0;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(1);
        check("reset_q", q, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_tick", zero_tick, 0);

        // start with q==0 is ignored
        start = 1; wait_clks(1); start = 0;
        check("idle_q0_start_busy", busy, 0);

        // countdown from 3, stop mode
        load_val = 8'd3; load = 1; wait_clks(1); load = 0;
        check("load3_q", q, 3);
        check("load3_busy", busy, 0);
        start = 1; wait_clks(1); start = 0;
        check("run3_busy", busy, 1);
        check("run3_q_first", q, 3);
        wait_clks(3); check("run3_q_last3", q, 3);
        wait_clks(1); check("run3_q2", q, 2);
        wait_clks(4); check("run3_q1", q, 1);
        wait_clks(4);
        check("run3_q0", q, 0);
        check("run3_tick", zero_tick, 1);
        check("run3_done", done, 1);
        check("run3_busy_off", busy, 0);
        wait_clks(1);
        check("run3_tick_once", zero_tick, 0);
        check("run3_done_hold", done, 1);

        // restart from DONE, then pause+start together
        start = 1; wait_clks(1); start = 0;
        check("restart_q", q, 3);
        check("restart_busy", busy, 1);
        wait_clks(3); check("restart_q_hold", q, 3);
        wait_clks(1); check("restart_q2", q, 2);
        pause = 1; start = 1; wait_clks(1); pause = 0; start = 0;
        check("pause_wins_busy", busy, 0);
        wait_clks(2); check("pause_wins_q", q, 2);

        // auto-reload from 2
        auto_reload = 1; load_val = 8'd2; load = 1; wait_clks(1); load = 0;
        start = 1; wait_clks(1); start = 0;
        check("ar_q2", q, 2);
        wait_clks(4); check("ar_q1", q, 1);
        wait_clks(4);
        check("ar_reload_q", q, 2);
        check("ar_reload_tick", zero_tick, 1);
        wait_clks(1); check("ar_tick_once", zero_tick, 0);
        wait_clks(7);
        check("ar_second_reload_tick", zero_tick, 1);
        check("ar_done_low", done, 0);
        auto_reload = 0;
        wait_clks(8);
        check("ar_off_q0", q, 0);
        check("ar_off_done", done, 1);

        // pause two clocks into the first period of 5
        load_val = 8'd5; load = 1; wait_clks(1); load = 0;
        start = 1; wait_clks(1); start = 0;
        wait_clks(2);
        pause = 1; wait_clks(10);
        check("paused_q", q, 5);
        check("paused_busy", busy, 0);
        pause = 0; start = 1; wait_clks(1); start = 0;
        check("resume_busy", busy, 1);
        check("resume_q", q, 5);
        wait_clks(1); check("resume_q_hold", q, 5);
        wait_clks(1); check("resume_first_step", q, 4);

        // load overrides a pending step
        wait_clks(3); check("pending_q", q, 4);
        load_val = 8'd9; load = 1; wait_clks(1); load = 0;
        check("load_override_q", q, 9);
        check("load_override_busy", busy, 0);
        check("load_override_tick", zero_tick, 0);
        wait_clks(1); check("load_override_hold", q, 9);

        // asynchronous reset mid-run
        start = 1; wait_clks(1); start = 0;
        wait_clks(5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_q", q, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_tick", zero_tick, 0);
        wait_clks(2);
        reset = 1'b0;
        wait_clks(2);
        check("post_rst_busy", busy, 0);
        check("post_rst_q", q, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
